pll2_lock_supervisor: RTL and testbench

Supervises the audio-codec clock PLL from the reference-clock side. It drives the PLL reset, watches the asynchronous `locked` flag, and measures the PLL output frequency against `refclk`. It releases the codec-domain reset only when the PLL is locked, the lock has been stable, and the measured frequency is in range. On loss of lock, lock timeout or a frequency fault it re-asserts the codec reset and re-runs the PLL reset sequence.

---
 rtl/pll2_lock_supervisor.sv | 167 ++++++++++++++++
 tb/tb_pll2_lock_supervisor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll2_lock_supervisor.sv
// PLL reset sequencer and lock/frequency supervisor, clocked by refclk.
// Define PLL2_LOCK_SUP_FREQ_CHECK_EN to compile in the meas_clk gate-window frequency check.
module pll2_lock_supervisor #(
  parameter int GATE_CYCLES    = 50000,
  parameter int EXP_MIN        = 2046,
  parameter int EXP_MAX        = 2050,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 5000000,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic        meas_clk,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        clk_ok,
  output logic [15:0] meas_count,
  output logic        meas_valid,
  output logic [7:0]  retry_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_SETTLE,
    S_MEASURE,
    S_RUN
  } state_t;

  state_t      state_reg;
  logic [31:0] timer_reg;
  logic [1:0]  locked_sync_reg;
  logic        locked_s;
  logic        run_fault;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) locked_sync_reg <= '0;
    else     locked_sync_reg <= {locked_sync_reg[0], locked};
  end

  assign locked_s = locked_sync_reg[1];

`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
  logic [2:0]  meas_sync_reg;
  logic [15:0] edge_cnt_reg;
  logic [15:0] win_count;
  logic        meas_edge;
  logic        in_window;
  logic        win_end;
  logic        in_range;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) meas_sync_reg <= '0;
    else     meas_sync_reg <= {meas_sync_reg[1:0], meas_clk};
  end

  assign meas_edge = meas_sync_reg[1] & ~meas_sync_reg[2];
  assign in_window = (state_reg == S_MEASURE) || (state_reg == S_RUN);
  assign win_end   = in_window && (timer_reg == 32'(GATE_CYCLES - 1));
  // Count including this cycle's edge so the final window cycle is not lost
  assign win_count = (meas_edge && (edge_cnt_reg != 16'hFFFF)) ? edge_cnt_reg + 16'd1 : edge_cnt_reg;
  assign in_range  = (win_count >= 16'(EXP_MIN)) && (win_count <= 16'(EXP_MAX));
  assign run_fault = !locked_s || (win_end && !in_range);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      edge_cnt_reg <= '0;
      meas_count   <= '0;
      meas_valid   <= 1'b0;
    end else begin
      edge_cnt_reg <= (!in_window || win_end) ? 16'd0 : win_count;
      meas_valid   <= win_end;
      if (win_end) meas_count <= win_count;
    end
  end
`else
  logic unused_cfg;

  assign run_fault  = !locked_s;
  assign meas_count = '0;
  assign meas_valid = 1'b0;
  assign unused_cfg = ^{meas_clk, 32'(GATE_CYCLES), 32'(EXP_MIN), 32'(EXP_MAX)};
`endif

  // Outputs are updated on the same edge as the state transition they follow
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RESET_PLL;
      timer_reg <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      clk_ok    <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state_reg)
        S_RESET_PLL: begin
          if (timer_reg == 32'(PLL_RST_CYCLES - 1)) begin
            state_reg <= S_WAIT_LOCK;
            pll_rst   <= 1'b0;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 32'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_reg <= S_SETTLE;
            timer_reg <= '0;
          end else if (timer_reg == 32'(LOCK_TIMEOUT - 1)) begin
            state_reg <= S_RESET_PLL;
            pll_rst   <= 1'b1;
            timer_reg <= '0;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            timer_reg <= timer_reg + 32'd1;
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            state_reg <= S_WAIT_LOCK;
            timer_reg <= '0;
          end else if (timer_reg == 32'(STABLE_CYCLES - 1)) begin
            timer_reg <= '0;
`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
            state_reg <= S_MEASURE;
`else
            state_reg <= S_RUN;
            sys_rst   <= 1'b0;
            clk_ok    <= 1'b1;
`endif
          end else begin
            timer_reg <= timer_reg + 32'd1;
          end
        end
        S_MEASURE, S_RUN: begin
          if (run_fault) begin
            state_reg <= S_RESET_PLL;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            clk_ok    <= 1'b0;
            timer_reg <= '0;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end
`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
          else if (win_end) begin
            state_reg <= S_RUN;
            sys_rst   <= 1'b0;
            clk_ok    <= 1'b1;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 32'd1;
          end
`endif
        end
        default: begin
          state_reg <= S_RESET_PLL;
          pll_rst   <= 1'b1;
          sys_rst   <= 1'b1;
          clk_ok    <= 1'b0;
          timer_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll2_lock_supervisor.sv
// Directed bench for pll2_lock_supervisor with shortened windows and timeouts.
module tb_pll2_lock_supervisor;

  localparam int GATE    = 200;
  localparam int EMIN    = 98;
  localparam int EMAX    = 102;
  localparam int STABLE  = 32;
  localparam int TIMEOUT = 1000;
  localparam int PRST    = 16;
`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
  localparam int FREQ_EXTRA = GATE;
  localparam int EXP_COUNT  = 100;  // meas_clk toggling every refclk cycle
  localparam int EXP_VALID  = 1;
`else
  localparam int FREQ_EXTRA = 0;
  localparam int EXP_COUNT  = 0;
  localparam int EXP_VALID  = 0;
`endif

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;
  logic        meas_clk = 1'b0;
  logic        pll_rst;
  logic        sys_rst;
  logic        clk_ok;
  logic [15:0] meas_count;
  logic        meas_valid;
  logic [7:0]  retry_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int meas_half = 1;
  int meas_ph = 0;

  pll2_lock_supervisor #(
    .GATE_CYCLES(GATE), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .STABLE_CYCLES(STABLE), .LOCK_TIMEOUT(TIMEOUT), .PLL_RST_CYCLES(PRST)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .meas_clk(meas_clk),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .clk_ok(clk_ok),
    .meas_count(meas_count), .meas_valid(meas_valid), .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  // meas_clk half-period is meas_half refclk cycles
  always @(negedge refclk) begin
    if (meas_ph >= meas_half - 1) begin
      meas_clk = ~meas_clk;
      meas_ph = 0;
    end else begin
      meas_ph = meas_ph + 1;
    end
  end

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    locked = 1'b0;
    repeat (3) tick;
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    tests_run++; if (sys_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
    tests_run++; if (clk_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_ok: got %b expected 0", clk_ok); end
    tests_run++; if (meas_count !== 16'd0) begin tests_failed++; $display("FAIL reset_meas_count: got %0d expected 0", meas_count); end
    tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
    tests_run++; if (retry_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_pll_rst_pulse;
    int n;
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick; n++; end
    tests_run++; if (n != PRST) begin tests_failed++; $display("FAIL pll_rst_width: got %0d expected %0d", n, PRST); end
    $display("[TB] test_pll_rst_pulse width=%0d", n);
  endtask

  task automatic test_lock_timeout;
    int n;
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (pll_rst === 1'b0 && n < 3000) begin tick; n++; end
      tests_run++; if (n != TIMEOUT) begin tests_failed++; $display("FAIL timeout_wait_%0d: got %0d expected %0d", k, n, TIMEOUT); end
      tests_run++; if (retry_cnt !== 8'(k)) begin tests_failed++; $display("FAIL timeout_retry_%0d: got %0d expected %0d", k, retry_cnt, k); end
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin tick; n++; end
      tests_run++; if (n != PRST) begin tests_failed++; $display("FAIL timeout_pulse_%0d: got %0d expected %0d", k, n, PRST); end
      $display("[TB] test_lock_timeout retry=%0d", retry_cnt);
    end
  endtask

  task automatic test_lock_and_run;
    int n;
    repeat (100) tick;
    locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 2000) begin tick; n++; end
    tests_run++; if (n != 3 + STABLE + FREQ_EXTRA) begin tests_failed++; $display("FAIL run_latency: got %0d expected %0d", n, 3 + STABLE + FREQ_EXTRA); end
    tests_run++; if (clk_ok !== 1'b1) begin tests_failed++; $display("FAIL run_clk_ok: got %b expected 1", clk_ok); end
    tests_run++; if (retry_cnt !== 8'd3) begin tests_failed++; $display("FAIL run_retry: got %0d expected 3", retry_cnt); end
    tests_run++; if (meas_count !== 16'(EXP_COUNT)) begin tests_failed++; $display("FAIL run_meas_count: got %0d expected %0d", meas_count, EXP_COUNT); end
    tests_run++; if (meas_valid !== 1'(EXP_VALID)) begin tests_failed++; $display("FAIL run_meas_valid: got %b expected %0d", meas_valid, EXP_VALID); end
    $display("[TB] test_lock_and_run latency=%0d count=%0d", n, meas_count);
  endtask

  task automatic test_lock_drop(input int exp_retry);
    int n;
    locked = 1'b0;
    tick;
    locked = 1'b1;
    n = 1;
    while (sys_rst === 1'b0 && n < 20) begin tick; n++; end
    tests_run++; if (n != 3) begin tests_failed++; $display("FAIL drop_sys_rst_latency: got %0d expected 3", n); end
    tests_run++; if (clk_ok !== 1'b0) begin tests_failed++; $display("FAIL drop_clk_ok: got %b expected 0", clk_ok); end
    tests_run++; if (retry_cnt !== 8'(exp_retry)) begin tests_failed++; $display("FAIL drop_retry: got %0d expected %0d", retry_cnt, exp_retry); end
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick; n++; end
    tests_run++; if (n != PRST) begin tests_failed++; $display("FAIL drop_pulse: got %0d expected %0d", n, PRST); end
    $display("[TB] test_lock_drop retry=%0d", retry_cnt);
  endtask

  task automatic test_settle_glitch;
    int n;
    repeat (10) tick;
    locked = 1'b0;
    tick;
    locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 2000) begin tick; n++; end
    tests_run++; if (n != 3 + STABLE + FREQ_EXTRA) begin tests_failed++; $display("FAIL glitch_latency: got %0d expected %0d", n, 3 + STABLE + FREQ_EXTRA); end
    tests_run++; if (retry_cnt !== 8'd4) begin tests_failed++; $display("FAIL glitch_retry: got %0d expected 4", retry_cnt); end
    tests_run++; if (clk_ok !== 1'b1) begin tests_failed++; $display("FAIL glitch_clk_ok: got %b expected 1", clk_ok); end
    $display("[TB] test_settle_glitch latency=%0d", n);
  endtask

`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
  task automatic test_freq_fault;
    int n;
    int saw_run;
    meas_half = 2;
    test_lock_drop(5);
    n = 0;
    saw_run = 0;
    while (meas_valid === 1'b0 && n < 1000) begin
      tick;
      n++;
      if (sys_rst === 1'b0) saw_run = 1;
    end
    tests_run++; if (n != 1 + STABLE + GATE) begin tests_failed++; $display("FAIL freq_window_end: got %0d expected %0d", n, 1 + STABLE + GATE); end
    tests_run++; if (meas_count !== 16'd50) begin tests_failed++; $display("FAIL freq_meas_count: got %0d expected 50", meas_count); end
    tests_run++; if (retry_cnt !== 8'd6) begin tests_failed++; $display("FAIL freq_retry: got %0d expected 6", retry_cnt); end
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL freq_pll_rst: got %b expected 1", pll_rst); end
    tests_run++; if (saw_run != 0 || sys_rst !== 1'b1) begin tests_failed++; $display("FAIL freq_sys_rst: got %b (run seen %0d) expected 1", sys_rst, saw_run); end
    meas_half = 1;
    $display("[TB] test_freq_fault count=%0d", meas_count);
  endtask
`endif

  task automatic test_reset_mid;
    int n;
`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick; n++; end
    repeat (1 + STABLE + GATE / 2) tick;
`else
    repeat (20) tick;
`endif
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL mid_pll_rst: got %b expected 1", pll_rst); end
    tests_run++; if (sys_rst !== 1'b1) begin tests_failed++; $display("FAIL mid_sys_rst: got %b expected 1", sys_rst); end
    tests_run++; if (clk_ok !== 1'b0) begin tests_failed++; $display("FAIL mid_clk_ok: got %b expected 0", clk_ok); end
    tests_run++; if (meas_count !== 16'd0) begin tests_failed++; $display("FAIL mid_meas_count: got %0d expected 0", meas_count); end
    tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_meas_valid: got %b expected 0", meas_valid); end
    tests_run++; if (retry_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_retry: got %0d expected 0", retry_cnt); end
    repeat (3) tick;
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick; n++; end
    tests_run++; if (n != PRST) begin tests_failed++; $display("FAIL mid_pulse: got %0d expected %0d", n, PRST); end
    n = 0;
    while (sys_rst === 1'b1 && n < 2000) begin tick; n++; end
    tests_run++; if (n != 1 + STABLE + FREQ_EXTRA) begin tests_failed++; $display("FAIL mid_restart_latency: got %0d expected %0d", n, 1 + STABLE + FREQ_EXTRA); end
    $display("[TB] test_reset_mid restart=%0d", n);
  endtask

  initial begin
    test_reset;
    test_pll_rst_pulse;
    test_lock_timeout;
    test_lock_and_run;
    test_lock_drop(4);
    test_settle_glitch;
`ifdef PLL2_LOCK_SUP_FREQ_CHECK_EN
    test_freq_fault;
`endif
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
